ppm_out_bank: RTL and testbench

//  N-channel PPM/servo pulse generator for the engine ESCs. It replaces per-engine ppm_out/io32 pairs with one bus peripheral.
//  The CPU writes per-channel shadow registers. A commit applies all channels atomically at the next frame boundary.
//  A failsafe watchdog forces minimum throttle if the CPU stops committing. Sits on the bus_controller beside the radio/IMU peripherals.

---
 rtl/ppm_pkg.sv | 28 ++
 rtl/ppm_timebase.sv | 46 ++++
 rtl/ppm_out_bank.sv | 166 ++++++++++++++++
 tb/tb_ppm_out_bank.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ppm_pkg.sv
// -----------------------------------------------------------------------------
// ppm_pkg
// Shared constants and sizing helpers for the PPM output bank.
//   CTRL_EN / CTRL_COMMIT / CTRL_FS : bit positions inside the CTRL register
//   cnt_w()   : bits needed for a counter running 0..n-1 (minimum 1)
//   pulse_w() : bits for the pulse-width compare. Wide enough for
//               MIN_US + max value and for FRAME_US, so widths at or beyond
//               the frame never wrap.
// -----------------------------------------------------------------------------
package ppm_pkg;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_COMMIT = 1;
  localparam int CTRL_FS     = 2;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int pulse_w(input int frame_us, input int min_us, input int val_w);
    int a;
    int b;
    a = $clog2(frame_us) + 1;
    b = $clog2(min_us + (1 << val_w)) + 1;
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ppm_timebase.sv
// -----------------------------------------------------------------------------
// ppm_timebase
// Microsecond timebase and frame counter for the PPM output bank.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   tick     out  one-cycle strobe, once per microsecond (prescaler terminal count)
//   us_cnt   out  microsecond position inside the frame, 0..FRAME_US-1
//   boundary out  tick on the last microsecond of the frame
// -----------------------------------------------------------------------------
module ppm_timebase
  import ppm_pkg::*;
#(
  parameter int CLK_DIV  = 50,
  parameter int FRAME_US = 20000,
  parameter int US_W     = cnt_w(FRAME_US)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            tick,
  output logic [US_W-1:0] us_cnt,
  output logic            boundary
);

  localparam int               PRE_W    = cnt_w(CLK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [US_W-1:0]  US_LAST  = US_W'(FRAME_US - 1);

  logic [PRE_W-1:0] pre_cnt;

  assign tick     = (pre_cnt == PRE_LAST);
  assign boundary = tick && (us_cnt == US_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      us_cnt  <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      us_cnt  <= (us_cnt == US_LAST) ? '0 : us_cnt + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ppm_out_bank.sv
// -----------------------------------------------------------------------------
// ppm_out_bank
// N-channel PPM/servo pulse generator for the engine ESCs. The CPU writes
// per-channel shadow registers; a commit copies all of them into the active
// set at the next frame boundary, so every channel changes in the same frame.
// Optional watchdog (build macro PPM_WDOG_EN): after WDOG_FRAMES boundaries
// without an applied commit, all channels drop to minimum throttle and
// FAILSAFE is raised until the next applied commit.
// Ports:
//   CLK         in   system clock
//   RESET       in   synchronous active-high reset
//   WE          in   bus write strobe (one cycle)
//   ADDR        in   0..CHANNELS-1 channel shadow, CHANNELS = CTRL
//   DATA_IN     in   write data; channels use [VAL_W-1:0]
//   DATA_OUT    out  combinational readback (shadow value or CTRL/status)
//   PPM         out  registered pulse outputs
//   FRAME_START out  one-cycle pulse the cycle after each frame boundary
//   FAILSAFE    out  watchdog override active (always 0 without PPM_WDOG_EN)
// CTRL layout: bit0 enable (R/W), bit1 commit/pending, bit2 failsafe (RO).
// -----------------------------------------------------------------------------
module ppm_out_bank
  import ppm_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int VAL_W       = 10,
  parameter int CLK_DIV     = 50,
  parameter int FRAME_US    = 20000,
  parameter int MIN_US      = 1000,
  parameter int WDOG_FRAMES = 50,
  localparam int AW         = $clog2(CHANNELS + 1)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                WE,
  input  logic [AW-1:0]       ADDR,
  input  logic [31:0]         DATA_IN,
  output logic [31:0]         DATA_OUT,
  output logic [CHANNELS-1:0] PPM,
  output logic                FRAME_START,
  output logic                FAILSAFE
);

  localparam int            US_W      = cnt_w(FRAME_US);
  localparam int            WW        = pulse_w(FRAME_US, MIN_US, VAL_W);
  localparam logic [AW-1:0] CTRL_ADDR = AW'(CHANNELS);

  logic [VAL_W-1:0] shadow [CHANNELS];
  logic [VAL_W-1:0] active [CHANNELS];
  logic [WW-1:0]    width  [CHANNELS];
  logic             enable;
  logic             en_next;
  logic             pending;
  logic             ctrl_we;
  logic             tick;
  logic             boundary;
  logic [US_W-1:0]  us_cnt;

  // Upper data bits and the raw tick are intentionally not consumed here.
  logic unused_ok;
  assign unused_ok = &{1'b0, DATA_IN[31:VAL_W], tick};

  ppm_timebase #(
    .CLK_DIV  (CLK_DIV),
    .FRAME_US (FRAME_US),
    .US_W     (US_W)
  ) u_timebase (
    .clk      (CLK),
    .rst      (RESET),
    .tick     (tick),
    .us_cnt   (us_cnt),
    .boundary (boundary)
  );

  assign ctrl_we = WE && (ADDR == CTRL_ADDR);

  // Disabling takes effect on the same edge that accepts the CTRL write.
  always_comb begin
    en_next = enable;
    if (ctrl_we) en_next = DATA_IN[CTRL_EN];
  end

  // Widths are computed wide enough that MIN_US + value >= FRAME_US simply
  // keeps the compare true all frame (constant-high output).
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      width[i] = WW'(MIN_US) + WW'(active[i]);
    end
  end

`ifdef PPM_WDOG_EN
  localparam int               WD_W    = cnt_w(WDOG_FRAMES + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WDOG_FRAMES);

  logic [WD_W-1:0] wdog;
  logic            failsafe_q;

  assign FAILSAFE = failsafe_q;
`else
  assign FAILSAFE = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      enable      <= 1'b0;
      pending     <= 1'b0;
      PPM         <= '0;
      FRAME_START <= 1'b0;
`ifdef PPM_WDOG_EN
      wdog        <= '0;
      failsafe_q  <= 1'b0;
`endif
    end else begin
      FRAME_START <= boundary;

      for (int i = 0; i < CHANNELS; i++) begin
        if (WE && (ADDR == AW'(i))) shadow[i] <= DATA_IN[VAL_W-1:0];
      end

      // The pending flag sampled here is the one set before this cycle, so a
      // commit written on the boundary cycle waits for the next boundary.
      if (boundary) begin
        if (pending) begin
          for (int i = 0; i < CHANNELS; i++) active[i] <= shadow[i];
          pending <= 1'b0;
`ifdef PPM_WDOG_EN
          wdog       <= '0;
          failsafe_q <= 1'b0;
        end else if (wdog != WD_LAST) begin
          wdog <= wdog + 1'b1;
          if (wdog == WD_LAST - 1'b1) begin
            failsafe_q <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) active[i] <= '0;
          end
`endif
        end
      end

      // Placed after the boundary clear so a new commit on that cycle survives.
      if (ctrl_we) begin
        enable <= DATA_IN[CTRL_EN];
        if (DATA_IN[CTRL_COMMIT]) pending <= 1'b1;
      end

      for (int i = 0; i < CHANNELS; i++) begin
        PPM[i] <= en_next && (WW'(us_cnt) < width[i]);
      end
    end
  end

  always_comb begin
    DATA_OUT = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ADDR == AW'(i)) DATA_OUT = 32'(shadow[i]);
    end
    if (ADDR == CTRL_ADDR) begin
      DATA_OUT[CTRL_EN]     = enable;
      DATA_OUT[CTRL_COMMIT] = pending;
      DATA_OUT[CTRL_FS]     = FAILSAFE;
    end
  end

endmodule

// File: tb/tb_ppm_out_bank.sv
// -----------------------------------------------------------------------------
// tb_ppm_out_bank
// Directed bench for ppm_out_bank with a shortened frame: CLK_DIV=2,
// FRAME_US=400, MIN_US=100, so one frame is 800 clocks and a value v gives
// (100+v)*2 high clocks, or the full 800 once 100+v >= 400.
// Expected results follow the watchdog build when PPM_WDOG_EN is defined.
// -----------------------------------------------------------------------------
module tb_ppm_out_bank;

  localparam int CHANNELS    = 4;
  localparam int VAL_W       = 10;
  localparam int CLK_DIV     = 2;
  localparam int FRAME_US    = 400;
  localparam int MIN_US      = 100;
  localparam int WDOG_FRAMES = 3;
  localparam int AW          = $clog2(CHANNELS + 1);
  localparam int FD          = FRAME_US * CLK_DIV;

`ifdef PPM_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                RESET;
  logic                WE;
  logic [AW-1:0]       ADDR;
  logic [31:0]         DATA_IN;
  logic [31:0]         DATA_OUT;
  logic [CHANNELS-1:0] PPM;
  logic                FRAME_START;
  logic                FAILSAFE;

  int n_chk  = 0;
  int n_pass = 0;
  int hi [CHANNELS];

  ppm_out_bank #(
    .CHANNELS    (CHANNELS),
    .VAL_W       (VAL_W),
    .CLK_DIV     (CLK_DIV),
    .FRAME_US    (FRAME_US),
    .MIN_US      (MIN_US),
    .WDOG_FRAMES (WDOG_FRAMES)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .WE          (WE),
    .ADDR        (ADDR),
    .DATA_IN     (DATA_IN),
    .DATA_OUT    (DATA_OUT),
    .PPM         (PPM),
    .FRAME_START (FRAME_START),
    .FAILSAFE    (FAILSAFE)
  );

  always #5 CLK = ~CLK;

  // High clocks per frame for a channel value v.
  function automatic int cyc(input int v);
    return (MIN_US + v >= FRAME_US) ? FD : (MIN_US + v) * CLK_DIV;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge CLK);
    WE = 1'b1; ADDR = AW'(a); DATA_IN = d;
    @(negedge CLK);
    WE = 1'b0; DATA_IN = '0;
  endtask

  task automatic chk_rd(input string tag, input int a, input logic [31:0] exp);
    ADDR = AW'(a);
    #1;
    chk(tag, DATA_OUT, exp);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!FRAME_START && n < 2 * FD);
    chk({tag, "_frame_start"}, 32'(FRAME_START), 32'd1);
  endtask

  // Counts high samples per channel over the next full frame; the last
  // sample lands on the following FRAME_START.
  task automatic measure();
    for (int c = 0; c < CHANNELS; c++) hi[c] = 0;
    for (int k = 0; k < FD; k++) begin
      @(negedge CLK);
      for (int c = 0; c < CHANNELS; c++) if (PPM[c]) hi[c]++;
    end
  endtask

  task automatic chk_frame(input string tag, input int e0, input int e1, input int e2, input int e3);
    chk({tag, "_ch0"}, 32'(hi[0]), 32'(e0));
    chk({tag, "_ch1"}, 32'(hi[1]), 32'(e1));
    chk({tag, "_ch2"}, 32'(hi[2]), 32'(e2));
    chk({tag, "_ch3"}, 32'(hi[3]), 32'(e3));
  endtask

  initial begin
    RESET = 1'b1; WE = 1'b0; ADDR = '0; DATA_IN = '0;
    repeat (3) @(negedge CLK);

    // Reset state
    chk("rst_ppm", 32'(PPM), 32'd0);
    chk("rst_frame_start", 32'(FRAME_START), 32'd0);
    chk("rst_failsafe", 32'(FAILSAFE), 32'd0);
    chk_rd("rst_ctrl", 4, 32'd0);
    chk_rd("rst_ch0", 0, 32'd0);
    RESET = 1'b0;

    // 1: ch0=150 committed -> 250 us pulse, others at minimum
    wr(0, 32'd150);
    wr(4, 32'd3);
    chk_rd("s1_ctrl_pending", 4, 32'd3);
    wait_start("s1");
    measure();
    chk_frame("s1", cyc(150), cyc(0), cyc(0), cyc(0));

    // 2: uncommitted shadow write, readback, out-of-range write ignored
    wr(1, 32'd40);
    chk_rd("s2_rd_ch1", 1, 32'd40);
    wr(5, 32'h0000_0002);
    chk_rd("s2_rd_ch0", 0, 32'd150);
    chk_rd("s2_rd_ch2", 2, 32'd0);
    chk_rd("s2_rd_addr5", 5, 32'd0);
    chk_rd("s2_ctrl", 4, 32'd1);
    wait_start("s2");
    measure();
    chk_frame("s2", cyc(150), cyc(0), cyc(0), cyc(0));

    // 4: three boundaries without commit have now passed
    chk("s4_failsafe", 32'(FAILSAFE), WD ? 32'd1 : 32'd0);
    chk_rd("s4_ctrl", 4, WD ? 32'd5 : 32'd1);
    wr(2, 32'd60);
    wait_start("s4");
    measure();
    chk_frame("s4", WD ? cyc(0) : cyc(150), cyc(0), cyc(0), cyc(0));

    // 3: commit lands exactly on the boundary edge -> applied one frame later
    repeat (FD - 1) @(negedge CLK);
    WE = 1'b1; ADDR = AW'(4); DATA_IN = 32'd3;
    @(negedge CLK);
    WE = 1'b0; DATA_IN = '0;
    chk("s3_frame_start", 32'(FRAME_START), 32'd1);
    chk_rd("s3_ctrl_pending", 4, WD ? 32'd7 : 32'd3);
    measure();
    chk_frame("s3_old", WD ? cyc(0) : cyc(150), cyc(0), cyc(0), cyc(0));
    chk("s3_frame_start_next", 32'(FRAME_START), 32'd1);
    chk("s3_failsafe_clr", 32'(FAILSAFE), 32'd0);
    chk_rd("s3_ctrl_applied", 4, 32'd1);
    measure();
    chk_frame("s3_new", cyc(150), cyc(40), cyc(60), cyc(0));

    // 6: saturation at full scale, then truncation of upper data bits
    wr(3, 32'd1023);
    wr(4, 32'd3);
    wait_start("s6a");
    measure();
    chk_frame("s6_sat", cyc(150), cyc(40), cyc(60), FD);
    wr(3, 32'hFFFF_FC05);
    chk_rd("s6_rd_trunc", 3, 32'd5);
    wr(4, 32'd3);
    wait_start("s6b");
    measure();
    chk_frame("s6_trunc", cyc(150), cyc(40), cyc(60), cyc(5));

    // enable=0 forces outputs low while counters keep running
    wr(4, 32'd0);
    @(negedge CLK);
    chk("dis_ppm", 32'(PPM), 32'd0);
    wr(4, 32'd1);

    // 5: reset in the middle of a ch2 pulse
    wait_start("s5");
    repeat (100) @(negedge CLK);
    chk("s5_ch2_high", 32'(PPM[2]), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("s5_ppm_low", 32'(PPM), 32'd0);
    chk("s5_failsafe", 32'(FAILSAFE), 32'd0);
    chk_rd("s5_ctrl", 4, 32'd0);
    chk_rd("s5_rd_ch2", 2, 32'd0);
    RESET = 1'b0;
    wait_start("s5_post");
    measure();
    chk_frame("s5_idle", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
